// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, bursts of up to BURST beats.
// Latency: zero; gnt/wrEn/wrIn are combinational from registered state, req and full.
// Backpressure: full=1 blocks every grant and freezes all state, so a burst stalls rather than ends.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int BURST = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     reqData,
    input  logic                      full,
    output logic [NREQ-1:0]           gnt,
    output logic                      wrEn,
    output logic [WIDTH-1:0]          wrIn,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);

    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_V = BW'(BURST);
    localparam logic [BW-1:0] ONE_V   = BW'(1);

    typedef enum logic {IDLE, BUSY} st_t;

    st_t             st, st_nxt;
    logic [OW-1:0]   ptr, ptr_nxt;
    logic [OW-1:0]   owner_nxt;
    logic [BW-1:0]   beat_cnt, beat_nxt, beat_inc;

    logic [OW-1:0]   search_start;
    logic [OW-1:0]   winner;
    logic            found;
    logic            do_grant;
    logic [OW-1:0]   gidx;

    // Index increment that wraps at NREQ-1 even when NREQ is not a power of two.
    function automatic logic [OW-1:0] inc_mod(input logic [OW-1:0] x);
        if (int'(x) == NREQ - 1) return '0;
        else return x + 1'b1;
    endfunction

    // Round-robin search; an owner that dropped its request mid-burst hands the search to the next index.
    always_comb begin
        logic [OW-1:0] idx;
        search_start = ptr;
        if (st == BUSY && !req[owner]) search_start = inc_mod(owner);
        found  = 1'b0;
        winner = '0;
        idx    = search_start;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = inc_mod(idx);
        end
    end

    assign beat_inc = beat_cnt + 1'b1;

    // Grant decision and next-state; nothing moves under reset or while the FIFO is full.
    always_comb begin
        do_grant  = 1'b0;
        gidx      = '0;
        st_nxt    = st;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        beat_nxt  = beat_cnt;
        if (!rst && !full) begin
            if (st == BUSY && req[owner]) begin
                do_grant = 1'b1;
                gidx     = owner;
                beat_nxt = beat_inc;
                if (beat_inc == BURST_V) begin
                    ptr_nxt = inc_mod(owner);
                    st_nxt  = IDLE;
                end
            end else begin
                // Early release: the burst ends now and the pointer moves past the old owner.
                if (st == BUSY) begin
                    ptr_nxt = inc_mod(owner);
                    st_nxt  = IDLE;
                end
                if (found) begin
                    do_grant  = 1'b1;
                    gidx      = winner;
                    owner_nxt = winner;
                    beat_nxt  = ONE_V;
                    if (BURST == 1) begin
                        ptr_nxt = inc_mod(winner);
                        st_nxt  = IDLE;
                    end else begin
                        st_nxt  = BUSY;
                    end
                end
            end
        end
    end

    // State register with synchronous reset; reset forgets any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            st       <= st_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    assign gnt  = do_grant ? (NREQ'(1) << gidx) : '0;
    assign wrEn = |gnt;
    assign wrIn = do_grant ? reqData[gidx*WIDTH +: WIDTH] : '0;
    assign busy = (st == BUSY) && !rst;

endmodule
